// File: rtl/dmem_pkg.sv
// Shared types for the data-memory arbiter: requester identity, the RAM access payload
// and the bus widths used by the interface, the top and the read tracker.
package dmem_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int HOLD_W = 8;

    typedef enum logic {
        OWN_C = 1'b0,
        OWN_D = 1'b1
    } owner_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] wmask;
    } mem_req_t;

    localparam mem_req_t MEM_REQ_IDLE = '0;

    function automatic owner_e other_owner(owner_e o);
        return (o == OWN_C) ? OWN_D : OWN_C;
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Bundle of the core port (c_*), the debug port (d_*) and the RAM port (ram_*).
// The arbiter connects through the slave modport; requesters and RAM sit on the master side.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic [MASK_W-1:0] c_wmask;
    logic              c_gnt;
    logic              c_stall;
    logic              c_rvalid;
    logic [DATA_W-1:0] c_rdata;

    logic              d_req;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic [MASK_W-1:0] d_wmask;
    logic              d_lock;
    logic              d_gnt;
    logic              d_rvalid;
    logic [DATA_W-1:0] d_rdata;

    logic              ram_oe;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata;
    logic [MASK_W-1:0] ram_wmask;
    logic [DATA_W-1:0] ram_rdata;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata, c_wmask,
        output c_gnt, c_stall, c_rvalid, c_rdata,
        input  d_req, d_we, d_addr, d_wdata, d_wmask, d_lock,
        output d_gnt, d_rvalid, d_rdata,
        output ram_oe, ram_we, ram_addr, ram_wdata, ram_wmask,
        input  ram_rdata
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata, c_wmask,
        input  c_gnt, c_stall, c_rvalid, c_rdata,
        output d_req, d_we, d_addr, d_wdata, d_wmask, d_lock,
        input  d_gnt, d_rvalid, d_rdata,
        input  ram_oe, ram_we, ram_addr, ram_wdata, ram_wmask,
        output ram_rdata
    );

endinterface

// File: rtl/dmem_rd_tracker.sv
// Tracks accepted reads through the RAM latency and steers the returning data
// to whichever port issued the read.
module dmem_rd_tracker
    import dmem_pkg::*;
#(
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  owner_e            owner_i,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              c_rvalid_o,
    output logic [DATA_W-1:0] c_rdata_o,
    output logic              d_rvalid_o,
    output logic [DATA_W-1:0] d_rdata_o
);

    logic [RD_LAT-1:0] valid_q;
    owner_e            owner_q [RD_LAT];
    logic              out_valid;
    owner_e            out_owner;

    // NOTE: the owner column is reset along with valid so the routing never sees X.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                owner_q[i] <= OWN_C;
            end
        end else begin
            valid_q[0] <= push_i;
            owner_q[0] <= owner_i;
            for (int i = 1; i < RD_LAT; i++) begin
                valid_q[i] <= valid_q[i-1];
                owner_q[i] <= owner_q[i-1];
            end
        end
    end

    assign out_valid  = valid_q[RD_LAT-1];
    assign out_owner  = owner_q[RD_LAT-1];

    assign c_rvalid_o = out_valid & (out_owner == OWN_C);
    assign d_rvalid_o = out_valid & (out_owner == OWN_D);
    assign c_rdata_o  = c_rvalid_o ? ram_rdata_i : '0;
    assign d_rdata_o  = d_rvalid_o ? ram_rdata_i : '0;

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-RAM port between the core (C) and a debug/loader master (D):
// per-cycle grant, round-robin on ties, optional D lock bounded by a starvation count.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int RD_LAT   = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic           clk,
    input  logic           rst,
    dmem_arbiter_if.slave  bus
);

    mem_req_t          c_pl;
    mem_req_t          d_pl;
    mem_req_t          ram_pl;

    owner_e            last_owner_q, last_owner_d;
    logic              lock_q, lock_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;

    logic              lock_live;
    logic              lock_wins;
    logic              c_gnt;
    logic              d_gnt;
    logic              any_gnt;

    assign c_pl = '{we: bus.c_we, addr: bus.c_addr, wdata: bus.c_wdata, wmask: bus.c_wmask};
    assign d_pl = '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, wmask: bus.d_wmask};

    // The lock only counts while D is still asking for it this cycle.
    assign lock_live = lock_q & bus.d_req & bus.d_lock;
    assign lock_wins = lock_live && (hold_cnt_q < HOLD_W'(MAX_HOLD));

    // NOTE: every output of a combinational block gets a default first, so no path infers a latch.
    always_comb begin
        c_gnt = 1'b0;
        d_gnt = 1'b0;
        if (!rst) begin
            if (bus.c_req && bus.d_req) begin
                if (lock_wins || other_owner(last_owner_q) == OWN_D) begin
                    d_gnt = 1'b1;
                end else begin
                    c_gnt = 1'b1;
                end
            end else begin
                c_gnt = bus.c_req;
                d_gnt = bus.d_req;
            end
        end
    end

    assign any_gnt = c_gnt | d_gnt;

    always_comb begin
        ram_pl = MEM_REQ_IDLE;
        if (c_gnt) begin
            ram_pl = c_pl;
        end else if (d_gnt) begin
            ram_pl = d_pl;
        end
    end

    assign bus.ram_oe    = any_gnt & ~ram_pl.we;
    assign bus.ram_we    = any_gnt &  ram_pl.we;
    assign bus.ram_addr  = ram_pl.addr;
    assign bus.ram_wdata = ram_pl.wdata;
    assign bus.ram_wmask = ram_pl.wmask;

    assign bus.c_gnt   = c_gnt;
    assign bus.d_gnt   = d_gnt;
    assign bus.c_stall = bus.c_req & ~c_gnt & ~rst;

    always_comb begin
        last_owner_d = last_owner_q;
        if (c_gnt) begin
            last_owner_d = OWN_C;
        end else if (d_gnt) begin
            last_owner_d = OWN_D;
        end

        lock_d = lock_q;
        if (!bus.d_req || !bus.d_lock) begin
            lock_d = 1'b0;
        end else if (d_gnt) begin
            lock_d = 1'b1;
        end

        // Counts only D grants won through the lock against a waiting core.
        hold_cnt_d = hold_cnt_q;
        if (c_gnt || !bus.d_req || !bus.d_lock) begin
            hold_cnt_d = '0;
        end else if (d_gnt && lock_live && bus.c_req) begin
            hold_cnt_d = hold_cnt_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_owner_q <= OWN_D;
            lock_q       <= 1'b0;
            hold_cnt_q   <= '0;
        end else begin
            last_owner_q <= last_owner_d;
            lock_q       <= lock_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    dmem_rd_tracker #(
        .RD_LAT (RD_LAT)
    ) u_rd_tracker (
        .clk         (clk),
        .rst         (rst),
        .push_i      (bus.ram_oe),
        .owner_i     (c_gnt ? OWN_C : OWN_D),
        .ram_rdata_i (bus.ram_rdata),
        .c_rvalid_o  (bus.c_rvalid),
        .c_rdata_o   (bus.c_rdata),
        .d_rvalid_o  (bus.d_rvalid),
        .d_rdata_o   (bus.d_rdata)
    );

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grants checked in-cycle, read returns checked
// against a scoreboard of expected {owner, data, due cycle}.
module tb_dmem_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_HOLD = 16;

    typedef struct {
        bit          own_d;
        logic [31:0] data;
        int          due;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb[$];

    dmem_arbiter_if bus ();

    dmem_arbiter #(
        .RD_LAT   (RD_LAT),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] ram_val(logic [31:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    // RAM model: data for a read issued in cycle t is presented in cycle t+RD_LAT.
    logic [31:0] ram_pipe [RD_LAT];
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RD_LAT; i++) ram_pipe[i] <= 32'h0;
        end else begin
            ram_pipe[0] <= bus.ram_oe ? ram_val(bus.ram_addr) : 32'h0;
            for (int i = 1; i < RD_LAT; i++) ram_pipe[i] <= ram_pipe[i-1];
        end
    end
    assign bus.ram_rdata = ram_pipe[RD_LAT-1];

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(string tag, logic obs, logic exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Read-return monitor; outputs only move on posedge, so negedge sampling is stable.
    always @(negedge clk) begin
        exp_t e;
        while (sb.size() > 0 && sb[0].due < cyc) begin
            check("rd_due_missed", cyc, sb[0].due);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_bit("c_rvalid", bus.c_rvalid, !e.own_d);
            check_bit("d_rvalid", bus.d_rvalid, e.own_d);
            check("c_rdata", bus.c_rdata, e.own_d ? 32'h0 : e.data);
            check("d_rdata", bus.d_rdata, e.own_d ? e.data : 32'h0);
        end else begin
            check_bit("c_rvalid_idle", bus.c_rvalid, 1'b0);
            check_bit("d_rvalid_idle", bus.d_rvalid, 1'b0);
            check("c_rdata_idle", bus.c_rdata, 32'h0);
            check("d_rdata_idle", bus.d_rdata, 32'h0);
        end
    end

    task automatic set_c(logic req, logic we, logic [31:0] addr, logic [31:0] wdata, logic [3:0] wmask);
        bus.c_req = req; bus.c_we = we; bus.c_addr = addr; bus.c_wdata = wdata; bus.c_wmask = wmask;
    endtask

    task automatic set_d(logic req, logic lock, logic we, logic [31:0] addr, logic [31:0] wdata,
                         logic [3:0] wmask);
        bus.d_req = req; bus.d_lock = lock; bus.d_we = we; bus.d_addr = addr;
        bus.d_wdata = wdata; bus.d_wmask = wmask;
    endtask

    task automatic idle();
        set_c(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        set_d(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic expect_read(bit own_d, logic [31:0] addr);
        sb.push_back('{own_d: own_d, data: ram_val(addr), due: cyc + RD_LAT});
    endtask

    task automatic check_all_zero(string tag);
        check_bit({tag, "_c_gnt"}, bus.c_gnt, 1'b0);
        check_bit({tag, "_d_gnt"}, bus.d_gnt, 1'b0);
        check_bit({tag, "_c_stall"}, bus.c_stall, 1'b0);
        check_bit({tag, "_ram_oe"}, bus.ram_oe, 1'b0);
        check_bit({tag, "_ram_we"}, bus.ram_we, 1'b0);
        check({tag, "_ram_addr"}, bus.ram_addr, 32'h0);
        check({tag, "_ram_wdata"}, bus.ram_wdata, 32'h0);
        check({tag, "_ram_wmask"}, {28'h0, bus.ram_wmask}, 32'h0);
        check_bit({tag, "_c_rvalid"}, bus.c_rvalid, 1'b0);
        check_bit({tag, "_d_rvalid"}, bus.d_rvalid, 1'b0);
        check({tag, "_c_rdata"}, bus.c_rdata, 32'h0);
        check({tag, "_d_rdata"}, bus.d_rdata, 32'h0);
    endtask

    task automatic pulse_reset();
        @(negedge clk); idle(); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
    endtask

    initial begin
        int waited;
        idle();

        // Reset: outputs stay 0 even with both requesters active.
        repeat (2) @(negedge clk);
        set_c(1'b1, 1'b1, 32'h44, 32'h1234_5678, 4'hF);
        set_d(1'b1, 1'b1, 1'b1, 32'h88, 32'h8765_4321, 4'hF);
        #1 check_all_zero("rst");
        @(negedge clk); idle(); rst = 1'b0;

        // Single core load.
        @(negedge clk); set_c(1'b1, 1'b0, 32'h100, 32'h0, 4'h0);
        #1;
        check_bit("t1_c_gnt", bus.c_gnt, 1'b1);
        check_bit("t1_c_stall", bus.c_stall, 1'b0);
        check_bit("t1_d_gnt", bus.d_gnt, 1'b0);
        check_bit("t1_ram_oe", bus.ram_oe, 1'b1);
        check_bit("t1_ram_we", bus.ram_we, 1'b0);
        check("t1_ram_addr", bus.ram_addr, 32'h100);
        expect_read(1'b0, 32'h100);
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        // Tie after reset: C wins first, then strict alternation.
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            set_c(1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
            set_d(1'b1, 1'b0, 1'b0, 32'h400, 32'h0, 4'h0);
            #1;
            check_bit("t2_c_gnt", bus.c_gnt, (i % 2) == 0);
            check_bit("t2_d_gnt", bus.d_gnt, (i % 2) == 1);
            check_bit("t2_c_stall", bus.c_stall, (i % 2) == 1);
            check("t2_ram_addr", bus.ram_addr, ((i % 2) == 0) ? 32'h300 : 32'h400);
            expect_read((i % 2) == 1, ((i % 2) == 0) ? 32'h300 : 32'h400);
        end
        @(negedge clk); idle();
        repeat (3) @(negedge clk);

        // Debug store: write strobes only, no read return.
        @(negedge clk); set_d(1'b1, 1'b0, 1'b1, 32'h200, 32'hDEAD_BEEF, 4'b0011);
        #1;
        check_bit("t4_d_gnt", bus.d_gnt, 1'b1);
        check_bit("t4_ram_we", bus.ram_we, 1'b1);
        check_bit("t4_ram_oe", bus.ram_oe, 1'b0);
        check("t4_ram_addr", bus.ram_addr, 32'h200);
        check("t4_ram_wdata", bus.ram_wdata, 32'hDEAD_BEEF);
        check("t4_ram_wmask", {28'h0, bus.ram_wmask}, 32'h3);
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        // Alternating single-port reads every cycle: returns must be gapless.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            idle();
            if ((i % 2) == 0) set_c(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 4'h0);
            else              set_d(1'b1, 1'b0, 1'b0, 32'h2000 + 32'(i * 4), 32'h0, 4'h0);
            #1;
            check_bit("t5_c_gnt", bus.c_gnt, (i % 2) == 0);
            check_bit("t5_d_gnt", bus.d_gnt, (i % 2) == 1);
            expect_read((i % 2) == 1, ((i % 2) == 0) ? 32'h1000 + 32'(i * 4) : 32'h2000 + 32'(i * 4));
        end
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        // Locked debug burst against a waiting core: MAX_HOLD D grants, one C, repeat.
        @(negedge clk); set_d(1'b1, 1'b1, 1'b1, 32'h600, 32'hCAFE_0000, 4'hF);
        #1 check_bit("t3_lock_open", bus.d_gnt, 1'b1);
        for (int round = 0; round < 2; round++) begin
            for (int i = 0; i < MAX_HOLD; i++) begin
                @(negedge clk); set_c(1'b1, 1'b0, 32'h500, 32'h0, 4'h0);
                #1;
                check_bit("t3_d_gnt_held", bus.d_gnt, 1'b1);
                check_bit("t3_c_stall_held", bus.c_stall, 1'b1);
            end
            @(negedge clk);
            #1;
            check_bit("t3_c_gnt_release", bus.c_gnt, 1'b1);
            check_bit("t3_d_gnt_release", bus.d_gnt, 1'b0);
            expect_read(1'b0, 32'h500);
        end
        // Dropping d_lock ends the burst: plain round-robin resumes.
        @(negedge clk); set_d(1'b1, 1'b0, 1'b1, 32'h600, 32'hCAFE_0001, 4'hF);
        #1 check_bit("t3_unlock_d_gnt", bus.d_gnt, 1'b1);
        @(negedge clk);
        #1 check_bit("t3_unlock_c_gnt", bus.c_gnt, 1'b1);
        expect_read(1'b0, 32'h500);
        @(negedge clk); idle();
        repeat (4) @(negedge clk);

        // Reset one cycle after an accepted read: that read never returns.
        @(negedge clk); set_c(1'b1, 1'b0, 32'h700, 32'h0, 4'h0);
        #1 check_bit("t6_c_gnt", bus.c_gnt, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        set_d(1'b1, 1'b0, 1'b1, 32'h704, 32'h5555_AAAA, 4'hF);
        #1 check_all_zero("t6_rst_a");
        @(negedge clk);
        #1 check_all_zero("t6_rst_b");
        @(negedge clk); idle(); rst = 1'b0;
        repeat (5) @(negedge clk);

        waited = 0;
        while (sb.size() > 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("sb_drained", 32'(sb.size()), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
